// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data RAM between the CPU (priority) and a host port,
// with a starvation counter that forces a waiting host request through.
module dmem_arbiter #(
   parameter int STARVE_LIM = 4,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Cpu_req,
   input  logic              Cpu_wr,
   input  logic [ADDR_W-1:0] Cpu_addr,
   input  logic [DATA_W-1:0] Cpu_wdata,
   output logic              Cpu_stall,
   output logic [DATA_W-1:0] Cpu_rdata,
   input  logic              Host_req,
   input  logic              Host_wr,
   input  logic [ADDR_W-1:0] Host_addr,
   input  logic [DATA_W-1:0] Host_wdata,
   output logic              Host_ack,
   output logic [DATA_W-1:0] Host_rdata,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic              Mem_wr,
   output logic [DATA_W-1:0] Mem_wdata,
   input  logic [DATA_W-1:0] Mem_rdata,
   output logic [1:0]        Grant_Out
);
   typedef enum logic {IDLE, HOST_ACK} state_t;
   localparam logic [3:0] LIM = 4'(STARVE_LIM);
   state_t     state, state_nxt;
   logic [3:0] wait_cnt, wait_cnt_nxt;
   logic       host_vis, grant_host, grant_cpu;
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   // Every grant is qualified by Reset so an asserted reset silences the RAM port immediately.
   always_comb begin
      host_vis     = Reset & Host_req & (state != HOST_ACK);
      grant_host   = host_vis & (~Cpu_req | (wait_cnt == LIM));
      grant_cpu    = Reset & Cpu_req & ~grant_host;
      state_nxt    = grant_host ? HOST_ACK : IDLE;
      wait_cnt_nxt = (grant_host | ~host_vis) ? 4'd0 : (wait_cnt == LIM) ? LIM : wait_cnt + 4'd1;
      Mem_addr     = grant_host ? Host_addr : grant_cpu ? Cpu_addr : '0;
      Mem_wr       = grant_host ? Host_wr : grant_cpu & Cpu_wr;
      Mem_wdata    = grant_host ? Host_wdata : grant_cpu ? Cpu_wdata : '0;
      Cpu_stall    = Reset & Cpu_req & ~grant_cpu;
      Grant_Out    = {grant_host, grant_cpu};
      Host_ack     = Reset & (state == HOST_ACK);
      Host_rdata   = Mem_rdata;
      Cpu_rdata    = Mem_rdata;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, hand-written reset sequences and randomized traffic,
// all checked against a transaction-level model of the arbiter and RAM.
module tb_dmem_arbiter;
   localparam int LIM = 4;
   logic        Clk, Reset;
   logic        Cpu_req, Cpu_wr, Cpu_stall;
   logic [7:0]  Cpu_addr;
   logic [15:0] Cpu_wdata, Cpu_rdata;
   logic        Host_req, Host_wr, Host_ack;
   logic [7:0]  Host_addr;
   logic [15:0] Host_wdata, Host_rdata;
   logic [7:0]  Mem_addr;
   logic        Mem_wr;
   logic [15:0] Mem_wdata, Mem_rdata;
   logic [1:0]  Grant_Out;

   dmem_arbiter #(.STARVE_LIM(LIM), .ADDR_W(8), .DATA_W(16)) dut (
      .Clk(Clk), .Reset(Reset),
      .Cpu_req(Cpu_req), .Cpu_wr(Cpu_wr), .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata),
      .Cpu_stall(Cpu_stall), .Cpu_rdata(Cpu_rdata),
      .Host_req(Host_req), .Host_wr(Host_wr), .Host_addr(Host_addr), .Host_wdata(Host_wdata),
      .Host_ack(Host_ack), .Host_rdata(Host_rdata),
      .Mem_addr(Mem_addr), .Mem_wr(Mem_wr), .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata),
      .Grant_Out(Grant_Out));

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Synchronous single-port RAM behind the arbiter
   logic [15:0] ram [256];
   always @(posedge Clk) begin
      if (Mem_wr) ram[Mem_addr] <= Mem_wdata;
      Mem_rdata <= ram[Mem_addr];
   end

   int checks = 0, errors = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction-level model: who owns the RAM this cycle, how long the host has been losing,
   // whether last cycle completed a host access, and what the RAM should return.
   logic [15:0] mem_model [256];
   bit          host_done_last;
   int          host_losses;
   bit          rdata_ok;
   logic [15:0] exp_rdata;
   bit          e_gh, e_gc, e_stall;
   logic [7:0]  e_addr;
   logic        e_wr;
   logic [15:0] e_wdata;

   task automatic check_model(input string tag);
      bit pending;
      pending = Reset && Host_req && !host_done_last;
      e_gh = pending && (!Cpu_req || host_losses >= LIM);
      e_gc = Reset && Cpu_req && !e_gh;
      e_stall = Reset && Cpu_req && !e_gc;
      e_addr  = e_gh ? Host_addr : e_gc ? Cpu_addr : 8'h00;
      e_wr    = e_gh ? Host_wr : (e_gc && Cpu_wr);
      e_wdata = e_gh ? Host_wdata : e_gc ? Cpu_wdata : 16'h0000;
      chk({tag, " grant"}, 32'(Grant_Out), {30'd0, e_gh, e_gc});
      chk({tag, " stall"}, 32'(Cpu_stall), 32'(e_stall));
      chk({tag, " mem_addr"}, 32'(Mem_addr), 32'(e_addr));
      chk({tag, " mem_wr"}, 32'(Mem_wr), 32'(e_wr));
      chk({tag, " mem_wdata"}, 32'(Mem_wdata), 32'(e_wdata));
      chk({tag, " host_ack"}, 32'(Host_ack), 32'(Reset && host_done_last));
      if (rdata_ok) chk({tag, " cpu_rdata"}, 32'(Cpu_rdata), 32'(exp_rdata));
      if (rdata_ok && Reset && host_done_last) chk({tag, " host_rdata"}, 32'(Host_rdata), 32'(exp_rdata));
      if (Reset && Host_req && !host_done_last && !e_gh) begin
         if (host_losses < LIM) host_losses = host_losses + 1;
      end else host_losses = 0;
      host_done_last = e_gh;
   endtask

   task automatic advance();
      @(posedge Clk);
      if (!Reset) begin
         host_done_last = 1'b0;
         host_losses = 0;
      end
      exp_rdata = mem_model[e_addr];
      if (e_wr) mem_model[e_addr] = e_wdata;
      rdata_ok = 1'b1;
      #1;
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                        input logic hr, input logic hw, input logic [7:0] ha, input logic [15:0] hd);
      Cpu_req = cr; Cpu_wr = cw; Cpu_addr = ca; Cpu_wdata = cd;
      Host_req = hr; Host_wr = hw; Host_addr = ha; Host_wdata = hd;
   endtask

   typedef struct {
      logic cr, cw; logic [7:0] ca; logic [15:0] cd;
      logic hr, hw; logic [7:0] ha; logic [15:0] hd;
      logic [1:0] g; logic st, ak, mw; logic [7:0] ma;
      logic rc; logic [15:0] rd;
   } vec_t;
   vec_t tbl [21];

   initial begin
      int k;
      bit h_pend;
      for (int i = 0; i < 256; i++) begin
         ram[i] = 16'h0000;
         mem_model[i] = 16'h0000;
      end
      host_done_last = 1'b0; host_losses = 0; rdata_ok = 1'b0; exp_rdata = 16'h0000;
      tbl[0] = '{1'b1, 1'b1, 8'h10, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 16'h0000};
      tbl[1] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 16'h0000};
      tbl[2] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h20, 16'hBEEF, 2'b10, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 16'h0000};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 16'h0000};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hBEEF};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 16'h0000};
      tbl[8] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hBEEF};
      for (int i = 9; i < 21; i++) begin
         k = (i - 9) % 6;
         tbl[i] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000,
                    (k == 4) ? 2'b10 : 2'b01, k == 4, k == 5, 1'b0, (k == 4) ? 8'h20 : 8'h10,
                    1'b1, (i == 9) ? 16'h0000 : (k == 5) ? 16'hBEEF : 16'h1234};
      end

      // Reset held low overrides active requests from both sides
      Reset = 1'b0;
      drive(1'b1, 1'b1, 8'h30, 16'h5555, 1'b1, 1'b1, 8'h31, 16'h7777);
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         chk("rst grant", 32'(Grant_Out), 32'd0);
         chk("rst mem_wr", 32'(Mem_wr), 32'd0);
         chk("rst ack", 32'(Host_ack), 32'd0);
         chk("rst stall", 32'(Cpu_stall), 32'd0);
         chk("rst mem_addr", 32'(Mem_addr), 32'd0);
         check_model("rst");
         advance();
      end
      Reset = 1'b1;
      @(negedge Clk);
      chk("release grant", 32'(Grant_Out), 32'h1);
      check_model("release");
      advance();
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge Clk); check_model("idle"); advance();

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].hr, tbl[i].hw, tbl[i].ha, tbl[i].hd);
         @(negedge Clk);
         chk($sformatf("vec%0d grant", i), 32'(Grant_Out), 32'(tbl[i].g));
         chk($sformatf("vec%0d stall", i), 32'(Cpu_stall), 32'(tbl[i].st));
         chk($sformatf("vec%0d ack", i), 32'(Host_ack), 32'(tbl[i].ak));
         chk($sformatf("vec%0d mem_wr", i), 32'(Mem_wr), 32'(tbl[i].mw));
         chk($sformatf("vec%0d mem_addr", i), 32'(Mem_addr), 32'(tbl[i].ma));
         if (tbl[i].rc) begin
            chk($sformatf("vec%0d cpu_rdata", i), 32'(Cpu_rdata), 32'(tbl[i].rd));
            if (tbl[i].ak) chk($sformatf("vec%0d host_rdata", i), 32'(Host_rdata), 32'(tbl[i].rd));
         end
         check_model($sformatf("vec%0d", i));
         advance();
      end

      // Reset pulse in the middle of a host write grant cycle
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge Clk); check_model("pre"); advance();
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h40, 16'hDEAD);
      #2 Reset = 1'b0;
      @(negedge Clk);
      chk("midrst mem_wr", 32'(Mem_wr), 32'd0);
      chk("midrst grant", 32'(Grant_Out), 32'd0);
      check_model("midrst");
      advance();
      Reset = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge Clk);
      chk("midrst no_ack", 32'(Host_ack), 32'd0);
      check_model("postrst"); advance();
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h40, 16'h0000);
      @(negedge Clk); check_model("rd40"); advance();
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge Clk);
      chk("midrst ram_unchanged", 32'(Host_rdata), 32'd0);
      chk("midrst rd_ack", 32'(Host_ack), 32'd1);
      check_model("rd40ack"); advance();
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h40, 16'hDEAD);
      @(negedge Clk);
      chk("rereq grant", 32'(Grant_Out), 32'h2);
      chk("rereq mem_wr", 32'(Mem_wr), 32'd1);
      check_model("rereq"); advance();
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge Clk);
      chk("rereq ack", 32'(Host_ack), 32'd1);
      check_model("rereqack"); advance();

      // Randomized traffic: CPU holds its request while stalled, host holds until its ack
      h_pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!e_stall) begin
            Cpu_req = ($urandom % 10) < 7;
            Cpu_wr = 1'($urandom);
            Cpu_addr = 8'($urandom % 8);
            Cpu_wdata = 16'($urandom);
         end
         if (host_done_last) begin
            h_pend = 1'b0;
            Host_req = 1'($urandom);
         end else if (!h_pend) begin
            h_pend = 1'($urandom);
            Host_req = h_pend;
            Host_wr = 1'($urandom);
            Host_addr = 8'($urandom % 8);
            Host_wdata = 16'($urandom);
         end else Host_req = 1'b1;
         @(negedge Clk);
         check_model($sformatf("rnd%0d", i));
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
